// File: rtl/mem_wb_responder.sv
// Memory-stage responder: accepts EX/MEM requests, services loads/stores against a
// word-addressed data memory and emits a registered write-back packet. Optional: MEM_WB_PERF_EN.
module mem_wb_responder #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_R,
    input  logic        i_W,
    input  logic        i_WE,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_WA,
    output logic        o_wb_valid,
    output logic        o_WE,
    output logic [4:0]  o_WA,
    output logic [31:0] o_WD,
`ifdef MEM_WB_PERF_EN
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_load_cnt,
`endif
    output logic        o_err
);

    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CW    = 4;
    localparam bit          MULTI = (LAT > 1);

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;

    // Request capture stage; s1_valid_q marks a request whose packet goes out next edge
    logic            s1_valid_q;
    logic            s1_load_q;
    logic            s1_err_q;
    logic            s1_we_q;
    logic [RW-1:0]   s1_wa_q;
    logic [DW-1:0]   s1_alu_q;
    logic [AW-1:0]   s1_idx_q;

    logic            wb_valid_q;
    logic            we_q;
    logic            err_q;
    logic [RW-1:0]   wa_q;
    logic [DW-1:0]   wd_q;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            accept_c;
    logic            load_c;
    logic            store_c;
    logic            err_c;
    logic [AW-1:0]   idx_c;
    logic            unused_c;

    assign accept_c = i_valid & ready_q;
    assign load_c   = i_R & ~i_W;
    assign store_c  = i_W & ~i_R;
    assign err_c    = i_R & i_W;
    assign idx_c    = i_alu[AW+1:2];
    assign unused_c = ^{i_alu[DW-1:AW+2], i_alu[1:0]};

    // Data memory: stores commit on the accept edge, contents are not reset
    always_ff @(posedge CLK) begin
        if (accept_c && store_c) begin
            mem_q[idx_c] <= i_data;
        end
    end

    // Control FSM and request capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_wa_q    <= '0;
            s1_alu_q   <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= 1'b0;
            if (accept_c) begin
                s1_load_q <= load_c;
                s1_err_q  <= err_c;
                s1_we_q   <= i_WE;
                s1_wa_q   <= i_WA;
                s1_alu_q  <= i_alu;
                s1_idx_q  <= idx_c;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        if (load_c && MULTI) begin
                            state_q <= S_LOAD;
                            cnt_q   <= CW'(LAT - 1);
                            ready_q <= 1'b0;
                        end else begin
                            s1_valid_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q    <= S_IDLE;
                        ready_q    <= 1'b1;
                        s1_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Write-back register; load data is read here, at completion
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_valid_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            wb_valid_q <= s1_valid_q;
            we_q       <= s1_valid_q & s1_we_q;
            err_q      <= s1_valid_q & s1_err_q;
            if (s1_valid_q) begin
                wa_q <= s1_wa_q;
                wd_q <= s1_load_q ? mem_q[s1_idx_q] : s1_alu_q;
            end
        end
    end

`ifdef MEM_WB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] load_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            if (i_valid && !ready_q) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (accept_c && load_c) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_load_cnt  = load_cnt_q;
`endif

    assign o_ready    = ready_q;
    assign o_wb_valid = wb_valid_q;
    assign o_WE       = we_q;
    assign o_WA       = wa_q;
    assign o_WD       = wd_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_mem_wb_responder.sv
// Directed bench for mem_wb_responder: one LAT=2 instance and one LAT=4 instance.
module tb_mem_wb_responder;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        valid, r, w, we;
    logic [4:0]  wa;
    logic [31:0] alu, data;
    logic        ready, wbv, owe, err;
    logic [4:0]  owa;
    logic [31:0] owd;

    logic        v4, r4, w4, we4;
    logic [4:0]  wa4;
    logic [31:0] alu4, d4;
    logic        ready4, wbv4, owe4, err4;
    logic [4:0]  owa4;
    logic [31:0] owd4;

`ifdef MEM_WB_PERF_EN
    logic [31:0] stall, lcnt, stall4, lcnt4;
`endif

    int total = 0;
    int bad   = 0;

    mem_wb_responder #(.DEPTH(256), .AW(8), .LAT(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .i_valid(valid), .o_ready(ready),
        .i_R(r), .i_W(w), .i_WE(we), .i_alu(alu), .i_data(data), .i_WA(wa),
        .o_wb_valid(wbv), .o_WE(owe), .o_WA(owa), .o_WD(owd),
`ifdef MEM_WB_PERF_EN
        .o_stall_cnt(stall), .o_load_cnt(lcnt),
`endif
        .o_err(err)
    );

    mem_wb_responder #(.DEPTH(256), .AW(8), .LAT(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .i_valid(v4), .o_ready(ready4),
        .i_R(r4), .i_W(w4), .i_WE(we4), .i_alu(alu4), .i_data(d4), .i_WA(wa4),
        .o_wb_valid(wbv4), .o_WE(owe4), .o_WA(owa4), .o_WD(owd4),
`ifdef MEM_WB_PERF_EN
        .o_stall_cnt(stall4), .o_load_cnt(lcnt4),
`endif
        .o_err(err4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk_pkt(input string tag, input logic e_we, input logic [4:0] e_wa,
                           input logic [31:0] e_wd, input logic e_err);
        check({tag, "_valid"}, 32'(wbv), 32'd1);
        check({tag, "_we"},    32'(owe), 32'(e_we));
        check({tag, "_wa"},    32'(owa), 32'(e_wa));
        check({tag, "_wd"},    owd, e_wd);
        check({tag, "_err"},   32'(err), 32'(e_err));
    endtask

    // Present one request to the LAT=2 instance; returns at the negedge after its accept edge
    task automatic send(input logic rr, input logic ww, input logic wwe, input logic [4:0] a,
                        input logic [31:0] al, input logic [31:0] d);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", 32'(ready), 32'd1);
        valid = 1'b1; r = rr; w = ww; we = wwe; wa = a; alu = al; data = d;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        valid = 0; r = 0; w = 0; we = 0; wa = '0; alu = '0; data = '0;
        v4 = 0; r4 = 0; w4 = 0; we4 = 0; wa4 = '0; alu4 = '0; d4 = '0;
        tick(); tick();
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_wbv",   32'(wbv),   32'd0);
        check("rst_we",    32'(owe),   32'd0);
        check("rst_wa",    32'(owa),   32'd0);
        check("rst_wd",    owd,        32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_ready4", 32'(ready4), 32'd1);
`ifdef MEM_WB_PERF_EN
        check("rst_stall", stall, 32'd0);
        check("rst_lcnt",  lcnt,  32'd0);
`endif
        tick();
        RST_N = 1'b1;

        // Pass-through: one cycle to packet, then single-cycle pulse with held WA/WD
        send(1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h0);
        check("pt_early", 32'(wbv), 32'd0);
        tick();
        chk_pkt("pt", 1'b1, 5'd3, 32'h0000_1234, 1'b0);
        tick();
        check("pt_pulse",   32'(wbv), 32'd0);
        check("pt_we_low",  32'(owe), 32'd0);
        check("pt_hold_wa", 32'(owa), 32'd3);
        check("pt_hold_wd", owd,      32'h0000_1234);

        // Store then adjacent load of the same word
        send(1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hDEAD_BEEF);
        send(1'b1, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0);
        chk_pkt("st", 1'b0, 5'd0, 32'h10, 1'b0);
        check("ld_stall", 32'(ready), 32'd0);
        tick();
        check("ld_ready_back", 32'(ready), 32'd1);
        check("ld_not_yet",    32'(wbv),   32'd0);
        tick();
        chk_pkt("ld", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);

        // Address wrap: 0x400 maps to word 0
        send(1'b0, 1'b1, 1'b0, 5'd0, 32'h400, 32'hCAFE_F00D);
        send(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0);
        tick(); tick();
        chk_pkt("wrap", 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0);

        // Illegal R+W: pass-through with err, memory untouched
        send(1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'h1111_2222);
        send(1'b1, 1'b1, 1'b1, 5'd9, 32'h20, 32'h9999_9999);
        tick();
        chk_pkt("ill", 1'b1, 5'd9, 32'h20, 1'b1);
        tick();
        check("ill_err_pulse", 32'(err), 32'd0);
        send(1'b1, 1'b0, 1'b1, 5'd2, 32'h20, 32'h0);
        tick(); tick();
        chk_pkt("ill_mem", 1'b1, 5'd2, 32'h1111_2222, 1'b0);

        // Reset in the middle of a load
        send(1'b1, 1'b0, 1'b1, 5'd4, 32'h10, 32'h0);
        check("mid_ready", 32'(ready), 32'd0);
        RST_N = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_wbv",   32'(wbv),   32'd0);
        check("mid_rst_wd",    owd,        32'd0);
        check("mid_rst_wa",    32'(owa),   32'd0);
`ifdef MEM_WB_PERF_EN
        check("mid_rst_lcnt", lcnt, 32'd0);
`endif
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_pkt", 32'(wbv), 32'd0);
        end
`ifdef MEM_WB_PERF_EN
        check("mid_stall", stall, 32'd0);
        check("mid_lcnt",  lcnt,  32'd0);
`endif

        // LAT=4: load with a pass-through held behind it
        v4 = 1; w4 = 1; r4 = 0; we4 = 0; wa4 = 5'd0; alu4 = 32'h8; d4 = 32'h0BAD_C0DE;
        tick();
        r4 = 1; w4 = 0; we4 = 1; wa4 = 5'd4;
        tick();
        check("l4_ready_e1", 32'(ready4), 32'd0);
        check("l4_st_pkt",   32'(wbv4),   32'd1);
        check("l4_st_wd",    owd4,        32'h8);
        r4 = 0; alu4 = 32'h55; wa4 = 5'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("l4_ready_low", 32'(ready4), 32'd0);
            check("l4_quiet",     32'(wbv4),   32'd0);
        end
        tick();
        check("l4_ready_back", 32'(ready4), 32'd1);
        check("l4_quiet2",     32'(wbv4),   32'd0);
        tick();
        v4 = 0;
        check("l4_ld_valid", 32'(wbv4), 32'd1);
        check("l4_ld_wa",    32'(owa4), 32'd4);
        check("l4_ld_wd",    owd4,      32'h0BAD_C0DE);
        check("l4_ld_we",    32'(owe4), 32'd1);
        tick();
        check("l4_pt_valid", 32'(wbv4), 32'd1);
        check("l4_pt_wa",    32'(owa4), 32'd6);
        check("l4_pt_wd",    owd4,      32'h55);
        tick();
        check("l4_done", 32'(wbv4), 32'd0);
        check("l4_err",  32'(err4), 32'd0);
`ifdef MEM_WB_PERF_EN
        check("l4_stall", stall4, 32'd3);
        check("l4_lcnt",  lcnt4,  32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
